// File: rtl/vga_scanout.sv
// vga_scanout: raster scanout of a 6-bit frame buffer to VGA, with sync and blank
// delayed to match the memory read latency and 2-to-8 bit colour expansion.
module vga_scanout #(
   parameter int H_VIS  = 640,
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int V_VIS  = 480,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33,
   parameter int RD_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        disp_en,
   output logic [18:0] raddr,
   output logic        re,
   input  logic [5:0]  rdata,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_blank_n,
   output logic        frame_start,
   output logic        vblank
);
   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int HW = $clog2(H_TOT);
   localparam int VW = $clog2(V_TOT);
   localparam logic [HW-1:0] H_VIS_C = HW'(H_VIS);
   localparam logic [HW-1:0] H_HS0   = HW'(H_VIS + H_FP);
   localparam logic [HW-1:0] H_HS1   = HW'(H_VIS + H_FP + H_SYNC);
   localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
   localparam logic [VW-1:0] V_VIS_C = VW'(V_VIS);
   localparam logic [VW-1:0] V_VS0   = VW'(V_VIS + V_FP);
   localparam logic [VW-1:0] V_VS1   = VW'(V_VIS + V_FP + V_SYNC);
   localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
   // pipeline word: {vis, hsync_n, vsync_n, disp}
   localparam logic [3:0] PIPE_RST = 4'b0110;

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic [18:0]   addr_q;
   logic          disp_q;
   logic          vis, h_end, v_end, origin, disp_frame, hs_raw, vs_raw, live;
   logic [3:0]    pipe [RD_LAT];

   always_comb begin
      h_end      = h_cnt == H_LAST;
      v_end      = v_cnt == V_LAST;
      vis        = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
      origin     = (h_cnt == '0) && (v_cnt == '0);
      disp_frame = origin ? disp_en : disp_q;
      hs_raw     = !((h_cnt >= H_HS0) && (h_cnt < H_HS1));
      vs_raw     = !((v_cnt >= V_VS0) && (v_cnt < V_VS1));
      live       = pipe[RD_LAT-1][3] & pipe[RD_LAT-1][0];
   end

   assign raddr       = addr_q;
   assign re          = vis;
   assign frame_start = origin & rst_n;
   assign vblank      = v_cnt >= V_VIS_C;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt  <= '0;
         v_cnt  <= '0;
         addr_q <= '0;
         disp_q <= 1'b0;
      end else begin
         h_cnt  <= h_end ? '0 : h_cnt + HW'(1);
         if (h_end) v_cnt <= v_end ? '0 : v_cnt + VW'(1);
         addr_q <= (h_end && v_end) ? '0 : addr_q + 19'(vis);
         if (origin) disp_q <= disp_en;
      end
   end

   // delay line matching the videoMem read latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RD_LAT; i++) pipe[i] <= PIPE_RST;
      end else begin
         pipe[0] <= {vis, hs_raw, vs_raw, disp_frame};
         for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vga_r       <= '0;
         vga_g       <= '0;
         vga_b       <= '0;
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         vga_blank_n <= 1'b0;
      end else begin
         vga_r       <= live ? {4{rdata[5:4]}} : '0;
         vga_g       <= live ? {4{rdata[3:2]}} : '0;
         vga_b       <= live ? {4{rdata[1:0]}} : '0;
         vga_hs      <= pipe[RD_LAT-1][2];
         vga_vs      <= pipe[RD_LAT-1][1];
         vga_blank_n <= live;
      end
   end
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: two shrunken-timing instances (RD_LAT 1 and 2) checked against a
// cycle-index raster model, plus a full-size instance checked over its first two lines.
module tb_vga_scanout;
   localparam int HV = 40, HF = 4, HS = 8, HB = 6;
   localparam int VV = 20, VF = 3, VS = 2, VB = 4;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int FT = HT * VT;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic disp_en = 1'b1;
   logic [5:0] salt;
   int checks = 0;
   int failures = 0;
   int kk;
   bit fd [64];

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n)
      if (!rst_n) kk <= 0;
      else kk <= kk + 1;

   always @(posedge clk)
      if (rst_n && (kk % FT == 0)) fd[(kk / FT) % 64] <= disp_en;

   function automatic logic [5:0] mem(input int a);
      return 6'(a) ^ salt;
   endfunction

   logic [18:0] ra [2];
   logic        re_s [2];
   logic [7:0]  r [2], g [2], b [2];
   logic        hs [2], vs [2], bn [2], fs [2], vb [2];

   for (genvar i = 0; i < 2; i++) begin : g_small
      logic [5:0] q [3];
      always @(posedge clk) begin
         q[0] <= re_s[i] ? mem(int'(ra[i])) : 6'($urandom);
         q[1] <= q[0];
         q[2] <= q[1];
      end
      vga_scanout #(.H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .RD_LAT(i + 1)) u (
         .clk(clk), .rst_n(rst_n), .disp_en(disp_en), .raddr(ra[i]), .re(re_s[i]),
         .rdata(q[i]), .vga_r(r[i]), .vga_g(g[i]), .vga_b(b[i]), .vga_hs(hs[i]),
         .vga_vs(vs[i]), .vga_blank_n(bn[i]), .frame_start(fs[i]), .vblank(vb[i]));
   end

   logic [18:0] ra_d;
   logic        re_d, hs_d, vs_d, bn_d, fs_d, vb_d;
   logic [7:0]  r_d, g_d, b_d;
   logic [5:0]  q_d;
   always @(posedge clk) q_d <= re_d ? mem(int'(ra_d)) : 6'($urandom);

   vga_scanout u_d (
      .clk(clk), .rst_n(rst_n), .disp_en(disp_en), .raddr(ra_d), .re(re_d),
      .rdata(q_d), .vga_r(r_d), .vga_g(g_d), .vga_b(b_d), .vga_hs(hs_d),
      .vga_vs(vs_d), .vga_blank_n(bn_d), .frame_start(fs_d), .vblank(vb_d));

   // Expected delayed outputs at cycle k for a DUT of read latency lat (+1 output register).
   function automatic void model(input int k, input int lat, output logic e_hs, output logic e_vs,
                                 output logic e_bn, output logic [7:0] e_r, output logic [7:0] e_g,
                                 output logic [7:0] e_b);
      int j, h, v;
      logic [5:0] d;
      j = k - lat - 1;
      e_hs = 1'b1; e_vs = 1'b1; e_bn = 1'b0; e_r = '0; e_g = '0; e_b = '0;
      if (j >= 0) begin
         h = j % HT;
         v = (j / HT) % VT;
         e_hs = !(h >= HV + HF && h < HV + HF + HS);
         e_vs = !(v >= VV + VF && v < VV + VF + VS);
         e_bn = (h < HV) && (v < VV) && fd[(j / FT) % 64];
         d = mem(v * HV + h);
         if (e_bn) begin
            e_r = {4{d[5:4]}};
            e_g = {4{d[3:2]}};
            e_b = {4{d[1:0]}};
         end
      end
   endfunction

   task automatic test_reset();
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({hs[d], vs[d], bn[d], fs[d], vb[d], re_s[d]} !== 6'b110001 || {r[d], g[d], b[d]} !== 24'h0 || ra[d] !== 19'd0) begin
            failures++;
            $display("FAIL reset_vals dut%0d got hs%b vs%b bn%b fs%b vb%b re%b rgb=%h ra=%0d exp hs1 vs1 bn0 fs0 vb0 re1 rgb=0 ra=0",
                     d, hs[d], vs[d], bn[d], fs[d], vb[d], re_s[d], {r[d], g[d], b[d]}, ra[d]);
         end
      end
      checks++;
      if ({hs_d, vs_d, bn_d, fs_d, vb_d} !== 5'b11000) begin
         failures++;
         $display("FAIL reset_vals_full got %b exp 11000", {hs_d, vs_d, bn_d, fs_d, vb_d});
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (fs[d] !== 1'b1 || ra[d] !== 19'd0 || re_s[d] !== 1'b1) begin
            failures++;
            $display("FAIL first_cycle dut%0d got fs%b ra=%0d re%b exp fs1 ra=0 re1", d, fs[d], ra[d], re_s[d]);
         end
      end
   endtask

   task automatic test_line_timing();
      logic e_hs, e_vs, e_bn;
      logic [7:0] e_r, e_g, e_b;
      int j, hd, vd;
      logic [5:0] dd;
      while (kk < 2 * 800 + 4) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            model(kk, d + 1, e_hs, e_vs, e_bn, e_r, e_g, e_b);
            checks++;
            if (hs[d] !== e_hs || bn[d] !== e_bn) begin
               failures++;
               $display("FAIL line_hs_bn dut%0d k=%0d got hs%b bn%b exp hs%b bn%b", d, kk, hs[d], bn[d], e_hs, e_bn);
            end
         end
         hd = kk % 800; vd = kk / 800;
         checks++;
         if (re_d !== (hd < 640 && vd < 480) || (re_d && ra_d !== 19'(vd * 640 + hd))) begin
            failures++;
            $display("FAIL full_addr k=%0d got re%b ra=%0d exp re%b ra=%0d", kk, re_d, ra_d, hd < 640, vd * 640 + hd);
         end
         j = kk - 2; hd = j % 800; vd = j / 800;
         dd = mem(vd * 640 + hd);
         e_hs = !(j >= 0 && hd >= 656 && hd < 752);
         e_bn = j >= 0 && hd < 640 && fd[0];
         checks++;
         if (hs_d !== e_hs || bn_d !== e_bn || vs_d !== 1'b1 || vb_d !== 1'b0 || fs_d !== (kk == 0)
             || {r_d, g_d, b_d} !== (e_bn ? {{4{dd[5:4]}}, {4{dd[3:2]}}, {4{dd[1:0]}}} : 24'h0)) begin
            failures++;
            $display("FAIL full_line k=%0d got hs%b bn%b vs%b vb%b fs%b rgb=%h exp hs%b bn%b", kk, hs_d, bn_d, vs_d, vb_d, fs_d, {r_d, g_d, b_d}, e_hs, e_bn);
         end
      end
   endtask

   task automatic test_frame_timing();
      logic e_hs, e_vs, e_bn;
      logic [7:0] e_r, e_g, e_b;
      repeat (2 * FT) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            model(kk, d + 1, e_hs, e_vs, e_bn, e_r, e_g, e_b);
            checks++;
            if (vs[d] !== e_vs || fs[d] !== (kk % FT == 0) || vb[d] !== ((kk / HT) % VT >= VV)) begin
               failures++;
               $display("FAIL frame dut%0d k=%0d got vs%b fs%b vb%b exp vs%b fs%b vb%b", d, kk, vs[d], fs[d], vb[d],
                        e_vs, kk % FT == 0, (kk / HT) % VT >= VV);
            end
         end
      end
   endtask

   task automatic test_addressing();
      int h, v;
      repeat (FT + HT) begin
         @(negedge clk);
         h = kk % HT; v = (kk / HT) % VT;
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (re_s[d] !== (h < HV && v < VV) || (re_s[d] && ra[d] !== 19'(v * HV + h))) begin
               failures++;
               $display("FAIL addr dut%0d h=%0d v=%0d got re%b ra=%0d exp re%b ra=%0d", d, h, v, re_s[d], ra[d], h < HV && v < VV, v * HV + h);
            end
         end
      end
   endtask

   task automatic test_full_check(input int n, input string tag);
      logic e_hs, e_vs, e_bn;
      logic [7:0] e_r, e_g, e_b;
      repeat (n) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            model(kk, d + 1, e_hs, e_vs, e_bn, e_r, e_g, e_b);
            checks++;
            if ({hs[d], vs[d], bn[d], r[d], g[d], b[d]} !== {e_hs, e_vs, e_bn, e_r, e_g, e_b}) begin
               failures++;
               $display("FAIL %s dut%0d k=%0d got hs%b vs%b bn%b rgb=%h exp hs%b vs%b bn%b rgb=%h", tag, d, kk,
                        hs[d], vs[d], bn[d], {r[d], g[d], b[d]}, e_hs, e_vs, e_bn, {e_r, e_g, e_b});
            end
         end
      end
   endtask

   task automatic test_colour();
      test_full_check(2 * FT, "colour");
   endtask

   task automatic test_disp_toggle();
      int tl, guard;
      tl = $urandom_range(1, VV - 2);
      guard = 0;
      while (kk % FT != tl * HT && guard < 2 * FT) begin
         @(posedge clk);
         guard++;
      end
      checks++;
      if (guard >= 2 * FT) begin
         failures++;
         $display("FAIL disp_wait timeout got %0d exp <%0d", guard, 2 * FT);
      end
      #1 disp_en = 1'b0;
      test_full_check(2 * FT, "disp_toggle");
   endtask

   task automatic test_mid_reset();
      int guard;
      guard = 0;
      while (!((kk / HT) % VT == 12 && kk % HT == 10) && guard < 2 * FT) begin
         @(negedge clk);
         guard++;
      end
      #2 rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({hs[d], vs[d], bn[d], fs[d], vb[d], re_s[d]} !== 6'b110001 || {r[d], g[d], b[d]} !== 24'h0 || ra[d] !== 19'd0) begin
            failures++;
            $display("FAIL mid_reset dut%0d got hs%b vs%b bn%b fs%b vb%b re%b rgb=%h ra=%0d exp hs1 vs1 bn0 fs0 vb0 re1 rgb=0 ra=0",
                     d, hs[d], vs[d], bn[d], fs[d], vb[d], re_s[d], {r[d], g[d], b[d]}, ra[d]);
         end
      end
      disp_en = 1'($urandom);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      test_full_check(FT + HT, "after_reset");
   endtask

   initial begin
      salt = 6'($urandom);
      test_reset();
      test_line_timing();
      test_frame_timing();
      test_addressing();
      test_colour();
      test_disp_toggle();
      test_mid_reset();
      test_frame_timing();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
